// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller and its datapath.
// Holds the opcode constants, the controller state enum and the
// ALUSrcB / ALUOp / PCSource mux encodings.
package mips_pkg;

    // Instruction opcodes (6-bit primary opcode field)
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b000100;
    localparam logic [5:0] OP_SW  = 6'b000101;
    localparam logic [5:0] OP_BEQ = 6'b000110;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;

    // Controller states; the encoding is visible on state_o
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        HALT   = 4'd10
    } state_t;

    // ALU B-operand select
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    // ALU operation class
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath.
// Ports:
//   clk, reset (async active-low)    -- clock and reset
//   opcode [OPW], mem_ready          -- IR opcode field, memory handshake
//   PCWrite .. Jal                   -- 1-bit datapath controls
//   ALUSrcB, ALUOp, PCSource [2]     -- mux / ALU selects (see mips_pkg)
//   illegal                          -- sticky undefined-opcode flag
//   state_o [4]                      -- current state (debug)
//   instr_count [WIDTH]              -- retired-instruction counter
module multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned OPW         = 6,
    parameter bit          MEM_WAIT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic             Jal,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal,
    output logic [3:0]       state_o,
    output logic [WIDTH-1:0] instr_count
);

    state_t         state;
    state_t         state_nx;
    logic [OPW-1:0] op_q;
    logic           rdy_c;
    logic           retire_c;

    assign rdy_c   = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign state_o = state;

    // Dispatch target for a freshly fetched opcode
    function automatic state_t decode_target(input logic [OPW-1:0] op);
        state_t t;
        if (op == OPW'(OP_LW) || op == OPW'(OP_SW))      t = MEMADR;
        else if (op == OPW'(OP_R))                       t = EXEC;
        else if (op == OPW'(OP_BEQ))                     t = BRANCH;
        else if (op == OPW'(OP_J) || op == OPW'(OP_JAL)) t = JUMP;
        else                                             t = HALT;
        return t;
    endfunction

    // State, latched opcode, sticky illegal flag and retire counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            op_q        <= '0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_nx;
            if (state == DECODE) op_q <= opcode;
            if (state_nx == HALT) illegal <= 1'b1;
            if (retire_c) instr_count <= instr_count + WIDTH'(1);
        end
    end

    // An instruction retires on the edge that leaves its final state
    always_comb begin
        retire_c = 1'b0;
        case (state)
            MEMWB, ALUWB, BRANCH, JUMP: retire_c = 1'b1;
            MEMWR:                      retire_c = rdy_c;
            default:                    retire_c = 1'b0;
        endcase
    end

    // Next-state logic; after DECODE only op_q steers the flow
    always_comb begin
        state_nx = state;
        case (state)
            FETCH:  if (rdy_c) state_nx = DECODE;
            DECODE: state_nx = decode_target(opcode);
            MEMADR: state_nx = (op_q == OPW'(OP_LW)) ? MEMRD : MEMWR;
            MEMRD:  if (rdy_c) state_nx = MEMWB;
            MEMWR:  if (rdy_c) state_nx = FETCH;
            EXEC:   state_nx = ALUWB;
            MEMWB, ALUWB, BRANCH, JUMP: state_nx = FETCH;
            HALT:   state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end

    // Moore output decode, forced quiet while reset is held
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        Jal         = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALU_ADD;
        PCSource    = PCSRC_ALU;
        if (reset) begin
            case (state)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = rdy_c;
                    PCWrite = rdy_c;
                end
                DECODE: ALUSrcB = SRCB_IMMSH2;
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALU_FUNCT;
                end
                ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                    if (op_q == OPW'(OP_JAL)) begin
                        RegWrite = 1'b1;
                        Jal      = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: three instances (default,
// WIDTH=4, MEM_WAIT_EN=0) share stimulus and are checked each cycle
// against an instruction-plan model; directed sequences pin the model.
module tb_multicycle_control;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;

    wire [17:0] ctl [3];
    wire [3:0]  sto [3];
    wire [31:0] cnt [3];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // ctl bits: 17 PCWrite 16 PCWriteCond 15 IorD 14 MemRead 13 MemWrite
    // 12 IRWrite 11 MemToReg 10 RegDst 9 RegWrite 8 ALUSrcA 7 Jal
    // 6:5 ALUSrcB 4:3 ALUOp 2:1 PCSource 0 illegal
    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int unsigned W = (g == 0) ? 32 : ((g == 1) ? 4 : 8);
            localparam bit MW = (g != 2);
            wire [17:0]  v;
            wire [3:0]   s;
            wire [W-1:0] c;
            multicycle_control #(.WIDTH(W), .OPW(6), .MEM_WAIT_EN(MW)) dut (
                .clk(clk), .reset(rst_n), .opcode(opcode), .mem_ready(mem_ready),
                .PCWrite(v[17]), .PCWriteCond(v[16]), .IorD(v[15]), .MemRead(v[14]),
                .MemWrite(v[13]), .IRWrite(v[12]), .MemToReg(v[11]), .RegDst(v[10]),
                .RegWrite(v[9]), .ALUSrcA(v[8]), .Jal(v[7]), .ALUSrcB(v[6:5]),
                .ALUOp(v[4:3]), .PCSource(v[2:1]), .illegal(v[0]),
                .state_o(s), .instr_count(c)
            );
            assign ctl[g] = v;
            assign sto[g] = s;
            assign cnt[g] = 32'(c);
        end
    endgenerate

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    state_t          m_st   [3];
    state_t          m_plan [3][4];
    int              m_len  [3];
    int              m_pos  [3];
    logic [5:0]      m_op   [3];
    longint unsigned m_cnt  [3];
    longint unsigned m_mod  [3] = '{64'h1_0000_0000, 64'd16, 64'd256};
    bit              m_mw   [3] = '{1'b1, 1'b1, 1'b0};

    // Control word required in a given state, written from the rule table
    function automatic logic [17:0] exp_ctrl(input state_t s, input logic [5:0] op, input bit rdy);
        logic pcw = 0, pcc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        logic m2r = 0, rdst = 0, rw = 0, srca = 0, jal = 0, ill = 0;
        logic [1:0] srcb = 2'b00, aluop = 2'b00, pcs = 2'b00;
        case (s)
            FETCH:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            DECODE: srcb = 2'b11;
            MEMADR: begin srca = 1; srcb = 2'b10; end
            MEMRD:  begin mrd = 1; iord = 1; end
            MEMWB:  begin rw = 1; m2r = 1; end
            MEMWR:  begin mwr = 1; iord = 1; end
            EXEC:   begin srca = 1; aluop = 2'b10; end
            ALUWB:  begin rdst = 1; rw = 1; end
            BRANCH: begin srca = 1; aluop = 2'b01; pcc = 1; pcs = 2'b01; end
            JUMP:   begin pcw = 1; pcs = 2'b10; if (op == 6'b000011) begin rw = 1; jal = 1; end end
            HALT:   ill = 1;
            default: ;
        endcase
        return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, jal, srcb, aluop, pcs, ill};
    endfunction

    task automatic model_reset(input int k);
        m_st[k] = FETCH; m_len[k] = 0; m_pos[k] = 0; m_op[k] = '0; m_cnt[k] = 0;
    endtask

    // One clock of instruction progress: FETCH, DECODE, then the opcode's plan
    task automatic model_step(input int k);
        bit r;
        r = m_mw[k] ? mem_ready : 1'b1;
        case (m_st[k])
            HALT: ;
            FETCH: if (r) m_st[k] = DECODE;
            DECODE: begin
                m_op[k] = opcode;
                case (opcode)
                    6'b000000: begin m_len[k] = 2; m_plan[k][0] = EXEC;   m_plan[k][1] = ALUWB; end
                    6'b000100: begin m_len[k] = 3; m_plan[k][0] = MEMADR; m_plan[k][1] = MEMRD;
                                     m_plan[k][2] = MEMWB; end
                    6'b000101: begin m_len[k] = 2; m_plan[k][0] = MEMADR; m_plan[k][1] = MEMWR; end
                    6'b000110: begin m_len[k] = 1; m_plan[k][0] = BRANCH; end
                    6'b000010, 6'b000011: begin m_len[k] = 1; m_plan[k][0] = JUMP; end
                    default:   begin m_len[k] = 1; m_plan[k][0] = HALT; end
                endcase
                m_st[k]  = m_plan[k][0];
                m_pos[k] = 1;
            end
            default: begin
                if (!((m_st[k] == MEMRD || m_st[k] == MEMWR) && !r)) begin
                    if (m_pos[k] < m_len[k]) begin
                        m_st[k] = m_plan[k][m_pos[k]];
                        m_pos[k]++;
                    end else begin
                        m_st[k]  = FETCH;
                        m_cnt[k] = (m_cnt[k] + 1) % m_mod[k];
                    end
                end
            end
        endcase
    endtask

    always @(posedge clk) begin
        if (rst_n) for (int k = 0; k < 3; k++) model_step(k);
    end

    // Per-cycle comparison of every instance against the model
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            bit r;
            if (!rst_n) model_reset(k);
            r = m_mw[k] ? mem_ready : 1'b1;
            chk($sformatf("ctl[%0d]", k), ctl[k], rst_n ? exp_ctrl(m_st[k], m_op[k], r) : 18'h0);
            chk($sformatf("state[%0d]", k), sto[k], m_st[k]);
            chk($sformatf("count[%0d]", k), cnt[k], m_cnt[k]);
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Walk one instruction on instance 0: per-cycle state nibbles and
    // mem_ready bits, opcode switching at cycle sw, one control-word check
    task automatic run_seq(input string nm, input logic [5:0] op_a, input logic [5:0] op_b,
                           input int sw, input int n, input logic [63:0] sts,
                           input logic [15:0] mrs, input int ci, input logic [17:0] cv);
        for (int i = 0; i < n; i++) begin
            opcode    = (i >= sw) ? op_b : op_a;
            mem_ready = mrs[i];
            #1;
            chk($sformatf("%s_st%0d", nm, i), sto[0], sts[4*i +: 4]);
            if (i == ci) chk($sformatf("%s_ctl", nm), ctl[0], cv);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk($sformatf("%s_end", nm), sto[0], sts[4*n +: 4]);
    endtask

    initial begin
        rst_n = 1'b0; opcode = 6'b0; mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", ctl[0], 18'h0);
        chk("rst_state", sto[0], 4'd0);
        chk("rst_count", cnt[0], 0);
        rst_n = 1'b1;

        run_seq("r",   6'h00, 6'h00, 99, 4, 64'h07610,   16'h0F, 3, 18'h00600);
        chk("r_count", cnt[0], 1);
        run_seq("lw",  6'h04, 6'h04, 99, 7, 64'h04333210, 16'h67, 6, 18'h00A00);
        chk("lw_count", cnt[0], 2);
        run_seq("jal", 6'h03, 6'h03, 99, 3, 64'h0910,    16'h07, 2, 18'h20284);
        chk("jal_count", cnt[0], 3);
        run_seq("sw",  6'h05, 6'h04, 2,  4, 64'h05210,   16'h0F, 3, 18'h0A000);
        chk("sw_count", cnt[0], 4);
        for (int i = 0; i < 12; i++) begin
            run_seq("beq", 6'h06, 6'h06, 99, 3, 64'h0810, 16'h07, 2, 18'h1010A);
            if (i == 10) chk("beq_w4_pre", cnt[1], 15);
        end
        chk("beq_w4_wrap", cnt[1], 0);
        chk("beq_w32", cnt[0], 16);

        mem_ready = 1'b0;
        #1;
        chk("fetch_wait_ctl", ctl[0], 18'h04020);
        tick();
        chk("fetch_wait_st", sto[0], 4'd0);

        run_seq("halt", 6'h3f, 6'h3f, 99, 2, 64'h0A10, 16'h03, 0, 18'h25020);
        for (int i = 0; i < 20; i++) begin
            opcode    = 6'($urandom);
            mem_ready = 1'($urandom);
            #1;
            chk("halt_st", sto[0], 4'd10);
            chk("halt_ctl", ctl[0], 18'h00001);
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("halt_rst_ill", ctl[0][0], 1'b0);
        chk("halt_rst_st", sto[0], 4'd0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            int r;
            rst_n = ($urandom_range(0, 99) != 0);
            r     = int'($urandom_range(0, 99));
            if (r < 3) opcode = 6'($urandom);
            else begin
                case ($urandom_range(0, 5))
                    0: opcode = 6'b000000;
                    1: opcode = 6'b000100;
                    2: opcode = 6'b000101;
                    3: opcode = 6'b000110;
                    4: opcode = 6'b000010;
                    default: opcode = 6'b000011;
                endcase
            end
            mem_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter WIDTH, default 32, sets datapath word width and instr_count width.
REQ-002 Parameter OPW, default 6, sets opcode width.
REQ-003 Parameter MEM_WAIT_EN, default 1: 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
REQ-004 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset.
REQ-006 Port opcode, input, OPW, instruction-register opcode field.
REQ-007 Port mem_ready, input, 1, memory access completes this cycle.
REQ-008 Ports PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA, Jal, output, 1 each, datapath controls.
REQ-009 Ports ALUSrcB, ALUOp, PCSource, output, 2 each: ALUSrcB 00=reg B, 01=const 4, 10=sign-ext imm, 11=imm<<2; ALUOp 00=add, 01=sub, 10=funct; PCSource 00=ALU, 01=ALUOut, 10=jump target.
REQ-010 Port illegal, output, 1, sticky undefined-opcode flag.
REQ-011 Port state_o, output, 4, current state encoding (debug).
REQ-012 Port instr_count, output, WIDTH, count of retired instructions.

Function
REQ-013 Controller is a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, HALT; every output not listed for a state is 0.
REQ-014 Opcodes: R=000000, LW=000100, SW=000101, BEQ=000110, J=000010, JAL=000011; all others undefined.
REQ-015 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready; stays in FETCH until mem_ready=1, then DECODE.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; opcode latched into internal op_q; next state LW/SW->MEMADR, R->EXEC, BEQ->BRANCH, J/JAL->JUMP, undefined->HALT.
REQ-017 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMRD if op_q=LW, else MEMWR.
REQ-018 MEMRD: MemRead=1, IorD=1; stays until mem_ready=1, then MEMWB.
REQ-019 MEMWB: RegWrite=1, MemToReg=1, RegDst=0; next FETCH.
REQ-020 MEMWR: MemWrite=1, IorD=1; stays until mem_ready=1, then FETCH.
REQ-021 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next ALUWB. ALUWB: RegDst=1, RegWrite=1, MemToReg=0; next FETCH.
REQ-022 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next FETCH.
REQ-023 JUMP: PCWrite=1, PCSource=10; if op_q=JAL also RegWrite=1, Jal=1; next FETCH.
REQ-024 HALT: all controls 0, illegal=1; remains in HALT until reset.
REQ-025 instr_count increments by 1, wrapping modulo 2^WIDTH, on each clock edge leaving MEMWB, ALUWB, BRANCH, JUMP, or MEMWR with mem_ready=1.
REQ-026 Decisions after DECODE use only op_q; opcode changes after DECODE have no effect.
REQ-027 Latencies with mem_ready=1 throughout: R 4, LW 5, SW 4, BEQ 3, J/JAL 3 cycles; each wait cycle adds 1.

Reset
REQ-028 reset=0 forces state FETCH, op_q=0, illegal=0 and instr_count=0 immediately, independent of clk.
REQ-029 While reset=0, all control outputs are 0.
REQ-030 Reset asserted mid-instruction (including during a memory wait) aborts the instruction without incrementing instr_count.
REQ-031 After reset deasserts, the first rising edge evaluates FETCH.

Structure
REQ-032 Package mips_pkg holds opcode constants, state enum, and ALUSrcB/ALUOp/PCSource encodings, shared with the datapath.
REQ-033 Single module; no sub-module, with next-state and output decode as separate combinational processes.

Verification
REQ-034 Under reset, opcode=000000 with mem_ready=1 -> state sequence FETCH, DECODE, EXEC, ALUWB, FETCH; RegWrite=1 and RegDst=1 only in ALUWB; instr_count=1.
REQ-035 opcode=000100 with mem_ready held 0 for 2 cycles in MEMRD -> MEMRD lasts 3 cycles, then MEMWB with MemToReg=1; total 7 cycles.
REQ-036 opcode=000011 -> JUMP asserts PCWrite=1, PCSource=10, Jal=1, RegWrite=1 for exactly 1 cycle.
REQ-037 opcode=111111 -> HALT, illegal=1, all controls 0 for 20 cycles; reset pulse clears illegal and returns to FETCH.
REQ-038 instr_count preloaded near 2^WIDTH-1 (WIDTH=4, 15 BEQs) then 1 more BEQ -> count wraps to 0.
REQ-039 opcode changed from 000101 to 000100 during MEMADR -> MEMWR still taken; MemWrite=1, MemRead=0.
